cd_param: RTL and testbench
===========================

// Module: cd_param
// PURPOSE
//  Parametrised single-cycle CPU datapath: PC, program ROM, register file, ALU, zero flag,
//  multi-port I/O, and a hardware return-address stack (RAS) for call/return.
//  Driven cycle by cycle by the external control unit, which decodes `opcode`.
//  Width, register count, port count and stack depth are generics.
// PARAMETERS
//  DW       8   data/register width
//  PCW      10  PC width; program ROM holds 2**PCW words
//  IW       16  instruction width; elaboration error if IW < OPW+PCW-4 or IW < 3*RAW
//  OPW      6   opcode width, taken from instr[IW-1 -: OPW]
//  NREG     16  register count, power of 2; RAW = $clog2(NREG)
//  NPORTS   2   I/O port count, power of 2; PSW = max(1, $clog2(NPORTS))
//  RAS_DEPTH 8  return-address stack entries (>=2)
//  IRQ_VEC  10'h3F0  interrupt entry address (used only with CD_IRQ_EN)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high
//  stall      in   1          1 = freeze all architectural state this cycle
//  s_pc       in   2          00 PC+1, 01 jump, 10 call, 11 return
//  we3        in   1          register-file write enable
//  wez        in   1          zero-flag write enable
//  s_we_port  in   1          output-port write enable
//  op_alu     in   3          ALU operation
//  sel_inputs in   2          WD3 source: 00 ALU, 01 input port, 10 RD1 (move), 11 immediate
//  in_p       in   NPORTS*DW  input ports, port k at [k*DW +: DW]
//  opcode     out  OPW        instr[IW-1 -: OPW]
//  z          out  1          registered zero flag
//  out_p      out  NPORTS*DW  registered output ports
//  stk_err    out  1          sticky RAS overflow/underflow
//  irq, irq_ack in/out 1      present only with CD_IRQ_EN
// BEHAVIOUR
//  - Fields: WA3=instr[RAW-1:0], RA2=instr[2*RAW-1:RAW], RA1=instr[3*RAW-1:2*RAW],
//    imm=instr[RAW +: DW], port index=instr[2*RAW +: PSW], target=instr[PCW-1:0].
//  - ROM and register reads are combinational. Register 0 reads as 0; writes to it are ignored.
//  - Reset: PC=0, z=0, out_p=0, RAS empty, stk_err=0, irq_ack=0. Register contents are undefined.
//  - Per edge with stall=0: PC <- next; reg[WA3] <- WD3 if we3; z <- (alu==0) if wez;
//    out_p[idx] <- RD2 if s_we_port. Write and read happen in the same cycle: a reg write is
//    visible to the next instruction; no bypass needed.
//  - stall=1: PC, regs, z, out_p, RAS, stk_err all hold; opcode keeps tracking the held PC.
//  - call (10): push PC+1, PC <- target. If RAS is full, the push is dropped, PC still jumps,
//    and stk_err <- 1.
//  - return (11): PC <- top, pop. If RAS is empty, PC <- PC+1 and stk_err <- 1.
//  - RAS is a circular-free LIFO with pointer range 0..RAS_DEPTH; PC+1 wraps mod 2**PCW.
//  - stk_err is cleared only by reset.
//  - Out-of-range port index (NPORTS not a power of 2 is disallowed): reads 0, writes are dropped.
// CONFIGURATION
//  CD_IRQ_EN defined:
//  - Adds `irq` (level) and `irq_ack`, plus an internal interrupt-enable flag ie (reset=1).
//  - When irq&ie&!stall:
//    - Push the current PC; the fetched instruction is discarded (we3, wez and s_we_port
//      are inhibited).
//    - PC <- IRQ_VEC, ie <- 0, z is saved in a shadow register, irq_ack pulses for 1 cycle.
//  - A RAS-full condition still takes the interrupt and sets stk_err.
//  - The first return with ie=0 sets ie <- 1 and restores z from the shadow.
//  CD_IRQ_EN undefined: no irq ports and no ie/shadow logic; behaviour is exactly as above.
// STRUCTURE
//  - Package cd_pkg: s_pc encodings (PC_INC, PC_JMP, PC_CALL, PC_RET), sel_inputs encodings
//    (SRC_ALU, SRC_PORT, SRC_MOV, SRC_IMM), op_alu codes.
//  - One sub-module, cd_ras: parametrised LIFO with push/pop/full/empty and a top output.
//  - Existing registro/mux/alu/regfile/memprog are reused at the parametrised widths.
// TESTING
//  1. Reset mid-program: assert reset asynchronously between edges -> PC=0, out_p=0, z=0
//     immediately, before the next clk edge.
//  2. Nested calls: call 0x100 from 0x005, then call 0x200 from 0x102, then ret, ret
//     -> PC sequence 0x100, 0x200, 0x103, 0x006; stk_err=0.
//  3. RAS_DEPTH=8: 9 consecutive calls -> 9th jumps, stk_err=1; then 9 rets -> the 9th goes
//     to PC+1 and stk_err stays 1.
//  4. stall=1 for 3 cycles with we3=1, wez=1, s_we_port=1 -> PC, regs, z, out_p unchanged.
//  5. NPORTS=4: write RD2=0xA5 to port 3 -> out_p[31:24]=0xA5 on the next edge, other ports 0;
//     read in_p port 2=0x3C with SRC_PORT into r5 -> r5=0x3C.
//  6. CD_IRQ_EN: irq at PC=0x020 with z=1 -> PC=IRQ_VEC, irq_ack=1 for 1 cycle; ISR clears z;
//     ret -> PC=0x020, z=1, ie=1.

Source files
------------

// File: rtl/cd_pkg.sv
// Shared encodings for the cd_param datapath: PC source select,
// register write-data source select and ALU operation codes.
package cd_pkg;

  // Next-PC source driven by the control unit on s_pc
  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_sel_e;

  // Register-file write-data source driven on sel_inputs
  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_PORT = 2'b01,
    SRC_MOV  = 2'b10,
    SRC_IMM  = 2'b11
  } src_sel_e;

  // ALU operations; A = RD1, B = RD2
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOTA  = 3'd5,
    ALU_PASSA = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

endpackage

// File: rtl/cd_ras.sv
// Return-address stack: bounded LIFO, pointer counts stored entries
// (0..DEPTH). Pushes when full and pops when empty are ignored; the
// caller decides what that means architecturally.
module cd_ras #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign top_idx = AW'(ptr_q - PW'(1));
  assign top_o   = mem_q[top_idx];

  // Pointer moves only on an accepted push or pop
  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o)       ptr_d = ptr_q + PW'(1);
    else if (pop_i && !empty_o)  ptr_d = ptr_q - PW'(1);
  end

  // Occupancy pointer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;

  // Entry storage; contents are meaningless while empty so no reset
  always_ff @(posedge clk_i)
    if (push_i && !full_o) mem_q[AW'(ptr_q)] <= din_i;

endmodule

// File: rtl/cd_param.sv
// Parametrised single-cycle datapath: PC, program ROM, register file,
// ALU, zero flag, multi-port I/O and a return-address stack.
// Optional feature macro: CD_IRQ_EN adds irq/irq_ack, an interrupt
// enable flag and a zero-flag shadow restored by the first return.
module cd_param
  import cd_pkg::*;
#(
  parameter int             DW        = 8,
  parameter int             PCW       = 10,
  parameter int             IW        = 16,
  parameter int             OPW       = 6,
  parameter int             NREG      = 16,
  parameter int             NPORTS    = 2,
  parameter int             RAS_DEPTH = 8,
  parameter logic [PCW-1:0] IRQ_VEC   = 10'h3F0,
  parameter logic [(2**PCW)-1:0][IW-1:0] ROM_INIT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [1:0]             s_pc,
  input  logic                   we3,
  input  logic                   wez,
  input  logic                   s_we_port,
  input  logic [2:0]             op_alu,
  input  logic [1:0]             sel_inputs,
  input  logic [NPORTS*DW-1:0]   in_p,
`ifdef CD_IRQ_EN
  input  logic                   irq,
  output logic                   irq_ack,
`endif
  output logic [OPW-1:0]         opcode,
  output logic                   z,
  output logic [NPORTS*DW-1:0]   out_p,
  output logic                   stk_err
);
  localparam int RAW = $clog2(NREG);
  localparam int PSW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  if (IW < OPW + PCW - 4 || IW < 3 * RAW) begin : g_bad_iw
    $error("cd_param: IW too narrow for opcode/target/register fields");
  end

  logic [PCW-1:0]        pc_q, pc_d, pc_inc, target, ras_top, ras_din;
  logic [IW-1:0]         instr;
  logic [RAW-1:0]        wa3, ra1, ra2;
  logic [PSW-1:0]        pidx;
  logic [DW-1:0]         imm, rd1, rd2, alu, pin, wd3;
  logic [DW-1:0]         rf_q [NREG];
  logic [NPORTS*DW-1:0]  out_q;
  logic                  z_q, err_q, err_set;
  logic                  ras_push, ras_pop, ras_full, ras_empty;
  logic                  irq_take, commit, z_restore, z_shadow;

  // Instruction fetch and field decode
  assign instr  = ROM_INIT[pc_q];
  assign opcode = instr[IW-1 -: OPW];
  assign wa3    = instr[RAW-1:0];
  assign ra2    = instr[2*RAW-1:RAW];
  assign ra1    = instr[3*RAW-1:2*RAW];
  assign imm    = instr[RAW +: DW];
  assign pidx   = instr[2*RAW +: PSW];
  assign target = instr[PCW-1:0];

  assign rd1 = (ra1 == '0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf_q[ra2];

  // An instruction's side effects land only when not stalled and not
  // displaced by an interrupt entry
  assign commit  = ~stall & ~irq_take;
  assign z       = z_q;
  assign out_p   = out_q;
  assign stk_err = err_q;

`ifdef CD_IRQ_EN
  logic ie_q, zsh_q, ack_q;
  assign irq_take  = irq & ie_q & ~stall;
  assign z_restore = commit & (s_pc == PC_RET) & ~ie_q;
  assign z_shadow  = zsh_q;
  assign irq_ack   = ack_q;

  // Interrupt enable, saved zero flag and one-cycle acknowledge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ie_q  <= 1'b1;
      zsh_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= irq_take;
      if (irq_take) begin
        ie_q  <= 1'b0;
        zsh_q <= z_q;
      end else if (z_restore) begin
        ie_q  <= 1'b1;
      end
    end
`else
  assign irq_take  = 1'b0;
  assign z_restore = 1'b0;
  assign z_shadow  = 1'b0;
`endif

  // ALU
  always_comb begin
    alu = '0;
    case (alu_op_e'(op_alu))
      ALU_ADD:   alu = rd1 + rd2;
      ALU_SUB:   alu = rd1 - rd2;
      ALU_AND:   alu = rd1 & rd2;
      ALU_OR:    alu = rd1 | rd2;
      ALU_XOR:   alu = rd1 ^ rd2;
      ALU_NOTA:  alu = ~rd1;
      ALU_PASSA: alu = rd1;
      ALU_PASSB: alu = rd2;
      default:   alu = '0;
    endcase
  end

  // Input-port read; an index past NPORTS reads zero
  always_comb begin
    pin = '0;
    for (int k = 0; k < NPORTS; k++)
      if (int'(pidx) == k) pin = in_p[k*DW +: DW];
  end

  // Register write-data source
  always_comb begin
    wd3 = alu;
    case (src_sel_e'(sel_inputs))
      SRC_ALU:  wd3 = alu;
      SRC_PORT: wd3 = pin;
      SRC_MOV:  wd3 = rd1;
      SRC_IMM:  wd3 = imm;
      default:  wd3 = alu;
    endcase
  end

  // Next PC and RAS control; interrupt entry overrides, stall freezes all
  always_comb begin
    pc_inc   = pc_q + PCW'(1);
    pc_d     = pc_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_din  = pc_inc;
    err_set  = 1'b0;
    case (pc_sel_e'(s_pc))
      PC_JMP:  pc_d = target;
      PC_CALL: begin
        pc_d     = target;
        ras_push = 1'b1;
        err_set  = ras_full;
      end
      PC_RET: begin
        if (ras_empty) err_set = 1'b1;
        else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end
      default: ;
    endcase
    if (irq_take) begin
      pc_d     = IRQ_VEC;
      ras_push = 1'b1;
      ras_pop  = 1'b0;
      ras_din  = pc_q;
      err_set  = ras_full;
    end
    if (stall) begin
      pc_d     = pc_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      err_set  = 1'b0;
    end
  end

  // PC, zero flag and sticky stack error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q  <= '0;
      z_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (err_set) err_q <= 1'b1;
      if (z_restore)           z_q <= z_shadow;
      else if (commit && wez)  z_q <= (alu == '0);
    end

  // Output ports; an out-of-range index drops the write
  always_ff @(posedge clk or posedge reset)
    if (reset) out_q <= '0;
    else if (commit && s_we_port)
      for (int k = 0; k < NPORTS; k++)
        if (int'(pidx) == k) out_q[k*DW +: DW] <= rd2;

  // Register file; r0 is hardwired to zero on read, so its writes are skipped
  always_ff @(posedge clk)
    if (commit && we3 && wa3 != '0) rf_q[wa3] <= wd3;

  cd_ras #(.W(PCW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .din_i   (ras_din),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

endmodule

// File: tb/tb_cd_param.sv
// Bench for cd_param (NPORTS=4): directed scenarios followed by random
// control sequences, all compared against a behavioural model.
module tb_cd_param;
  localparam int ROMN = 1024;
  localparam int RASD = 8;
  localparam int IRQV = 10'h3F0;
  localparam logic [1:0] INC = 2'd0, JMP = 2'd1, CALL = 2'd2, RET = 2'd3;
  localparam logic [1:0] S_ALU = 2'd0, S_PORT = 2'd1, S_IMM = 2'd3;
  localparam logic [2:0] OP_SUB = 3'd1, OP_NOTA = 3'd5;

  typedef logic [ROMN-1:0][15:0] rom_t;

  // Pseudo-random program with a few hand-placed fields for directed tests
  function automatic rom_t build_rom();
    rom_t r;
    logic [31:0] h;
    for (int a = 0; a < ROMN; a++) begin
      h = 32'(a) * 32'h9E3779B1 + 32'h7F4A7C15;
      h = h ^ (h >> 15);
      h = h * 32'h2C1B3C6D;
      h = h ^ (h >> 12);
      r[a] = h[15:0];
    end
    r[0][9:0]      = 10'h300;
    r[5][9:0]      = 10'h100;
    r[6][9:0]      = 10'h300;
    r[10'h102][9:0] = 10'h200;
    for (int a = 0; a < 16; a++) r[10'h300 + a][3:0] = 4'(a);
    r[10'h310][11:0] = 12'hA57;   // imm A5 -> r7
    r[10'h311][9:4]  = 6'h37;     // port 3 <- r7
    r[10'h312][9:8]  = 2'd2;      // r5 <- in port 2
    r[10'h312][3:0]  = 4'd5;
    r[10'h313][9:4]  = 6'h05;     // port 0 <- r5
    r[10'h314][11:4] = 8'h33;     // r3 - r3
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  logic        clk, reset, stall, we3, wez, s_we_port, z, stk_err;
  logic [1:0]  s_pc, sel_inputs;
  logic [2:0]  op_alu;
  logic [31:0] in_p, out_p;
  logic [5:0]  opcode;
`ifdef CD_IRQ_EN
  logic irq, irq_ack;
`endif

  cd_param #(.NPORTS(4), .ROM_INIT(ROM)) dut (
    .clk(clk), .reset(reset), .stall(stall), .s_pc(s_pc), .we3(we3), .wez(wez),
    .s_we_port(s_we_port), .op_alu(op_alu), .sel_inputs(sel_inputs), .in_p(in_p),
`ifdef CD_IRQ_EN
    .irq(irq), .irq_ack(irq_ack),
`endif
    .opcode(opcode), .z(z), .out_p(out_p), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int         m_pc;
  logic [7:0] m_r [16];
  logic [7:0] m_out [4];
  logic       m_z, m_err, m_ie, m_zsh, m_ack;
  int         m_stk [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 1'b0; m_err = 1'b0; m_ie = 1'b1; m_zsh = 1'b0; m_ack = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    m_stk.delete();
  endtask

  // Drive one cycle, advance the model, then compare after the edge
  task automatic step(input logic st, input logic [1:0] sp, input logic w3, input logic wz,
                      input logic wp, input logic [2:0] op, input logic [1:0] sel,
                      input logic [31:0] inp, input logic iq);
    logic [15:0] w;
    logic [7:0]  a, b, res, wd;
    int          wa3, ra1, ra2, idx, tgt;
    logic        take;
    stall = st; s_pc = sp; we3 = w3; wez = wz; s_we_port = wp;
    op_alu = op; sel_inputs = sel; in_p = inp;
`ifdef CD_IRQ_EN
    irq = iq;
`endif
    w   = ROM[m_pc];
    wa3 = int'(w[3:0]); ra2 = int'(w[7:4]); ra1 = int'(w[11:8]);
    idx = int'(w[9:8]); tgt = int'(w[9:0]);
    a = (ra1 == 0) ? 8'h00 : m_r[ra1];
    b = (ra2 == 0) ? 8'h00 : m_r[ra2];
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~a;
      3'd6: res = a;
      default: res = b;
    endcase
    case (sel)
      2'd0: wd = res;
      2'd1: wd = inp[idx*8 +: 8];
      2'd2: wd = a;
      default: wd = w[11:4];
    endcase
    take  = !st && iq && m_ie;
    m_ack = take;
    if (take) begin
      if (m_stk.size() < RASD) m_stk.push_back(m_pc); else m_err = 1'b1;
      m_zsh = m_z; m_ie = 1'b0; m_pc = IRQV;
    end else if (!st) begin
      if (w3 && wa3 != 0) m_r[wa3] = wd;
      if (wz) m_z = (res == 8'h00);
      if (wp) m_out[idx] = b;
      case (sp)
        2'd0: m_pc = (m_pc + 1) % ROMN;
        2'd1: m_pc = tgt;
        2'd2: begin
          if (m_stk.size() < RASD) m_stk.push_back((m_pc + 1) % ROMN); else m_err = 1'b1;
          m_pc = tgt;
        end
        default: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = (m_pc + 1) % ROMN; m_err = 1'b1; end
          if (!m_ie) begin m_ie = 1'b1; m_z = m_zsh; end
        end
      endcase
    end
    @(posedge clk); #1;
    chk("opcode", opcode, ROM[m_pc][15:10]);
    chk("z", z, m_z);
    chk("out_p", out_p, {m_out[3], m_out[2], m_out[1], m_out[0]});
    chk("stk_err", stk_err, m_err);
`ifdef CD_IRQ_EN
    chk("irq_ack", irq_ack, m_ack);
`endif
  endtask

  task automatic plain(input logic [1:0] sp);
    step(1'b0, sp, 1'b0, 1'b0, 1'b0, 3'($urandom), 2'($urandom), $urandom, 1'b0);
  endtask

  task automatic init_regs();
    for (int i = 0; i < 16; i++)
      step(1'b0, INC, 1'b1, 1'b0, 1'b0, 3'($urandom), S_IMM, $urandom, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; s_pc = INC; we3 = 1'b0; wez = 1'b0; s_we_port = 1'b0;
    op_alu = 3'd0; sel_inputs = 2'd0; in_p = 32'h0;
`ifdef CD_IRQ_EN
    irq = 1'b0;
`endif
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
    model_reset();
    #1;
    chk("rst_opcode", opcode, ROM[0][15:10]);
    chk("rst_z", z, 1'b0);
    chk("rst_out_p", out_p, 32'h0);
    chk("rst_stk_err", stk_err, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Load every register, then the port write/read scenario
    plain(JMP);
    init_regs();
    step(1'b0, INC, 1'b1, 1'b0, 1'b0, 3'($urandom), S_IMM, $urandom, 1'b0);
    step(1'b0, INC, 1'b0, 1'b0, 1'b1, 3'($urandom), 2'($urandom), $urandom, 1'b0);
    chk("port3_a5", out_p[31:24], 8'hA5);
    chk("ports012_zero", out_p[23:0], 24'h0);
    step(1'b0, INC, 1'b1, 1'b0, 1'b0, 3'($urandom), S_PORT,
         {8'($urandom), 8'h3C, 16'($urandom)}, 1'b0);
    step(1'b0, INC, 1'b0, 1'b0, 1'b1, 3'($urandom), 2'($urandom), $urandom, 1'b0);
    chk("r5_via_port0", out_p[7:0], 8'h3C);
    step(1'b0, INC, 1'b0, 1'b1, 1'b0, OP_SUB, S_ALU, $urandom, 1'b0);
    chk("z_set", z, 1'b1);

    // Stall with every write enable raised
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'($urandom), 1'b1, 1'b1, 1'b1, 3'($urandom), 2'($urandom), $urandom, 1'b0);
      chk("stall_pc", opcode, ROM[10'h315][15:10]);
      chk("stall_z", z, 1'b1);
      chk("stall_out_p", out_p, 32'hA500_003C);
    end

`ifdef CD_IRQ_EN
    // Interrupt entry with z=1, ISR rewrites z, return restores it
    step(1'b0, INC, 1'b1, 1'b1, 1'b1, 3'($urandom), 2'($urandom), $urandom, 1'b1);
    chk("irq_vec", opcode, ROM[IRQV][15:10]);
    chk("irq_ack_hi", irq_ack, 1'b1);
    chk("irq_out_hold", out_p, 32'hA500_003C);
    step(1'b0, INC, 1'b0, 1'b1, 1'b0, OP_NOTA, S_ALU, $urandom, 1'b0);
    chk("irq_ack_lo", irq_ack, 1'b0);
    plain(RET);
    chk("irq_ret_pc", opcode, ROM[10'h315][15:10]);
    chk("irq_ret_z", z, 1'b1);
    step(1'b0, INC, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, $urandom, 1'b1);
    chk("irq_ie_back", irq_ack, 1'b1);
`endif

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_opcode", opcode, ROM[0][15:10]);
    chk("arst_z", z, 1'b0);
    chk("arst_out_p", out_p, 32'h0);
    chk("arst_stk_err", stk_err, 1'b0);
    model_reset();
    @(negedge clk); reset = 1'b0;

    // Nested calls 0x005 -> 0x100, 0x102 -> 0x200, then two returns
    for (int i = 0; i < 5; i++) plain(INC);
    plain(CALL); chk("nest_0x100", opcode, ROM[10'h100][15:10]);
    plain(INC); plain(INC);
    plain(CALL); chk("nest_0x200", opcode, ROM[10'h200][15:10]);
    plain(RET);  chk("nest_0x103", opcode, ROM[10'h103][15:10]);
    plain(RET);  chk("nest_0x006", opcode, ROM[6][15:10]);
    chk("nest_no_err", stk_err, 1'b0);

    // Reload registers, then overflow and underflow the stack
    plain(JMP);
    init_regs();
    for (int i = 0; i < 9; i++) begin
      plain(CALL);
      if (i == 7) chk("ras_8_ok", stk_err, 1'b0);
    end
    chk("ras_overflow", stk_err, 1'b1);
    for (int i = 0; i < 9; i++) plain(RET);
    chk("ras_underflow_sticky", stk_err, 1'b1);

    // Random control sequences
    for (int n = 0; n < 600; n++) begin
      logic iq;
      iq = 1'b0;
`ifdef CD_IRQ_EN
      iq = ($urandom_range(15) == 0);
`endif
      step($urandom_range(7) == 0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom), 2'($urandom), $urandom, iq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
